// File: rtl/pipe_pkg.sv
// Shared types for elastic pipeline stages: occupancy encoding, default widths
// and the stage payload structs that instances size DATA_W from.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_e;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wb_en;
    } mem_wb_payload_t;

    function automatic logic [1:0] occ_count(input occ_e s);
        case (s)
            OCC_ONE: return 2'd1;
            OCC_TWO: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Valid/ready payload channel; master drives valid/data, slave drives ready.
interface pipe_stage_hs_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_hs_sat_counter.sv
// Saturating up-counter for performance events; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         r_cnt <= '0;
        else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_hs.sv
// Elastic pipeline register with valid/ready handshake, flush, optional
// two-entry skid buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                SKID      = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    pipe_stage_hs_if.slave   i_up,
    pipe_stage_hs_if.master  o_dn,
    output logic [1:0]       o_occupancy,
    output logic [CNT_W-1:0] o_stall_cnt
);

    occ_e              r_state;
    logic              r_out_valid;
    logic              r_in_ready;
    logic [1:0]        r_occ;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    occ_e w_nxt;
    logic w_in_ready;
    logic w_in_fire;
    logic w_out_fire;
    logic w_ld_main;
    logic w_ld_skid;
    logic w_main_from_skid;

    // Without the skid entry, a full stage can only accept when it drains.
    assign w_in_ready = (SKID != 0) ? r_in_ready : (!r_out_valid || o_dn.ready);
    assign w_in_fire  = i_up.valid && w_in_ready;
    assign w_out_fire = r_out_valid && o_dn.ready;

    always_comb begin
        w_nxt            = r_state;
        w_ld_main        = 1'b0;
        w_ld_skid        = 1'b0;
        w_main_from_skid = 1'b0;
        if (i_flush) begin
            w_nxt = OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: if (w_in_fire) begin
                    w_nxt     = OCC_ONE;
                    w_ld_main = 1'b1;
                end
                OCC_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_ld_main = 1'b1;
                    end else if (w_in_fire) begin
                        w_nxt     = OCC_TWO;
                        w_ld_skid = 1'b1;
                    end else if (w_out_fire) begin
                        w_nxt = OCC_EMPTY;
                    end
                end
                OCC_TWO: if (w_out_fire) begin
                    w_nxt            = OCC_ONE;
                    w_ld_main        = 1'b1;
                    w_main_from_skid = 1'b1;
                end
                default: w_nxt = OCC_EMPTY;
            endcase
        end
    end

    // Status outputs are registered from the next state so none of them
    // has a combinational path from out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= OCC_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_occ       <= 2'd0;
            r_main      <= RESET_VAL;
            r_skid      <= '0;
        end else begin
            r_state     <= w_nxt;
            r_out_valid <= (w_nxt != OCC_EMPTY);
            r_in_ready  <= (w_nxt != OCC_TWO);
            r_occ       <= occ_count(w_nxt);
            if (w_ld_main) r_main <= w_main_from_skid ? r_skid : i_up.data;
            if (w_ld_skid) r_skid <= i_up.data;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (r_out_valid && !o_dn.ready),
        .o_cnt (o_stall_cnt)
    );

    assign i_up.ready  = w_in_ready;
    assign o_dn.valid  = r_out_valid;
    assign o_dn.data   = r_main;
    assign o_occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench: skid stage (32b), single-entry stage (32b), 4-bit-counter stage (8b).
module tb_pipe_stage_hs;
    import pipe_pkg::*;

    logic clk, rst;
    logic sk_flush, ns_flush, c4_flush;
    logic [1:0]  sk_occ, ns_occ, c4_occ;
    logic [15:0] sk_stall, ns_stall;
    logic [3:0]  c4_stall;
    int errors = 0;
    int checks = 0;

    pipe_stage_hs_if #(.DATA_W(32)) sk_in ();
    pipe_stage_hs_if #(.DATA_W(32)) sk_out ();
    pipe_stage_hs_if #(.DATA_W(32)) ns_in ();
    pipe_stage_hs_if #(.DATA_W(32)) ns_out ();
    pipe_stage_hs_if #(.DATA_W(8))  c4_in ();
    pipe_stage_hs_if #(.DATA_W(8))  c4_out ();

    pipe_stage_hs #(.DATA_W(32), .SKID(1), .RESET_VAL(32'hDEAD_BEEF), .CNT_W(16)) u_sk (
        .clk(clk), .rst(rst), .i_flush(sk_flush), .i_up(sk_in), .o_dn(sk_out),
        .o_occupancy(sk_occ), .o_stall_cnt(sk_stall));
    pipe_stage_hs #(.DATA_W(32), .SKID(0), .RESET_VAL(32'h0), .CNT_W(16)) u_ns (
        .clk(clk), .rst(rst), .i_flush(ns_flush), .i_up(ns_in), .o_dn(ns_out),
        .o_occupancy(ns_occ), .o_stall_cnt(ns_stall));
    pipe_stage_hs #(.DATA_W(8), .SKID(1), .RESET_VAL(8'h0), .CNT_W(4)) u_c4 (
        .clk(clk), .rst(rst), .i_flush(c4_flush), .i_up(c4_in), .o_dn(c4_out),
        .o_occupancy(c4_occ), .o_stall_cnt(c4_stall));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sk_out.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", sk_out.valid); end
        checks++; if (sk_occ !== 2'd0) begin errors++; $display("FAIL rst_occ got=%0d exp=0", sk_occ); end
        checks++; if (sk_out.data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_data got=%h exp=deadbeef", sk_out.data); end
        checks++; if (sk_stall !== 16'd0) begin errors++; $display("FAIL rst_stall got=%0d exp=0", sk_stall); end
        rst = 1'b0;
        step();
        checks++; if (sk_in.ready !== 1'b1) begin errors++; $display("FAIL rst_sk_in_ready got=%b exp=1", sk_in.ready); end
        checks++; if (ns_in.ready !== 1'b1) begin errors++; $display("FAIL rst_ns_in_ready got=%b exp=1", ns_in.ready); end
    endtask

    task automatic test_stream();
        sk_out.ready = 1'b1;
        sk_in.valid  = 1'b1;
        sk_in.data   = 32'h1;
        for (int i = 1; i <= 16; i++) begin
            step();
            checks++;
            if (sk_out.valid !== 1'b1 || sk_out.data !== 32'(i))
                begin errors++; $display("FAIL stream_%0d got v=%b d=%h exp v=1 d=%h", i, sk_out.valid, sk_out.data, i); end
            checks++; if (sk_in.ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got=%b exp=1", i, sk_in.ready); end
            if (i < 16) sk_in.data = 32'(i + 1);
            else        sk_in.valid = 1'b0;
        end
        step();
        checks++; if (sk_out.valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", sk_out.valid); end
        checks++; if (sk_stall !== 16'd0) begin errors++; $display("FAIL stream_stall got=%0d exp=0", sk_stall); end
    endtask

    task automatic test_skid();
        sk_out.ready = 1'b0;
        sk_in.valid  = 1'b1;
        sk_in.data   = 32'hA;
        step();
        checks++; if (sk_out.data !== 32'hA || sk_occ !== 2'd1) begin errors++; $display("FAIL skid_first got d=%h occ=%0d exp d=a occ=1", sk_out.data, sk_occ); end
        sk_in.data = 32'hB;
        step();
        checks++; if (sk_occ !== 2'd2) begin errors++; $display("FAIL skid_occ2 got=%0d exp=2", sk_occ); end
        checks++; if (sk_in.ready !== 1'b0) begin errors++; $display("FAIL skid_full_ready got=%b exp=0", sk_in.ready); end
        sk_in.data = 32'hC;
        step();
        checks++; if (sk_occ !== 2'd2 || sk_out.data !== 32'hA) begin errors++; $display("FAIL skid_hold got occ=%0d d=%h exp occ=2 d=a", sk_occ, sk_out.data); end
        checks++; if (sk_stall !== 16'd2) begin errors++; $display("FAIL skid_stall got=%0d exp=2", sk_stall); end
        sk_out.ready = 1'b1;
        step();
        checks++; if (sk_out.data !== 32'hB || sk_occ !== 2'd1) begin errors++; $display("FAIL skid_out_b got d=%h occ=%0d exp d=b occ=1", sk_out.data, sk_occ); end
        checks++; if (sk_in.ready !== 1'b1) begin errors++; $display("FAIL skid_reopen got=%b exp=1", sk_in.ready); end
        step();
        checks++; if (sk_out.valid !== 1'b1 || sk_out.data !== 32'hC) begin errors++; $display("FAIL skid_out_c got v=%b d=%h exp v=1 d=c", sk_out.valid, sk_out.data); end
        sk_in.valid = 1'b0;
        step();
        checks++; if (sk_out.valid !== 1'b0) begin errors++; $display("FAIL skid_empty got=%b exp=0", sk_out.valid); end
        checks++; if (sk_stall !== 16'd2) begin errors++; $display("FAIL skid_stall_end got=%0d exp=2", sk_stall); end
    endtask

    task automatic test_flush();
        sk_out.ready = 1'b0;
        sk_in.valid  = 1'b1;
        sk_in.data   = 32'h11;
        step();
        sk_in.data = 32'h12;
        step();
        sk_in.data = 32'hD;
        sk_flush   = 1'b1;
        step();
        sk_flush    = 1'b0;
        sk_in.valid = 1'b0;
        checks++; if (sk_out.valid !== 1'b0 || sk_occ !== 2'd0) begin errors++; $display("FAIL flush_kill got v=%b occ=%0d exp v=0 occ=0", sk_out.valid, sk_occ); end
        checks++; if (sk_in.ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", sk_in.ready); end
        checks++; if (sk_stall !== 16'd4) begin errors++; $display("FAIL flush_stall got=%0d exp=4", sk_stall); end
        sk_out.ready = 1'b1;
        step();
        checks++; if (sk_out.valid !== 1'b0) begin errors++; $display("FAIL flush_no_d got=%b exp=0", sk_out.valid); end
        sk_in.valid = 1'b1;
        sk_in.data  = 32'hE;
        step();
        sk_in.valid = 1'b0;
        checks++; if (sk_out.valid !== 1'b1 || sk_out.data !== 32'hE) begin errors++; $display("FAIL flush_then_e got v=%b d=%h exp v=1 d=e", sk_out.valid, sk_out.data); end
        step();
        checks++; if (sk_out.valid !== 1'b0) begin errors++; $display("FAIL flush_e_drain got=%b exp=0", sk_out.valid); end
    endtask

    task automatic test_noskid();
        logic        m_valid;
        logic [31:0] m_data, nxt, out_seq;
        logic        exp_rdy;
        m_valid = 1'b0; m_data = '0; nxt = 32'd1; out_seq = 32'd1;
        for (int c = 0; c < 24; c++) begin
            ns_out.ready = (c % 2 == 0);
            ns_in.valid  = 1'b1;
            ns_in.data   = nxt;
            #1;
            exp_rdy = !m_valid || ns_out.ready;
            checks++; if (ns_in.ready !== exp_rdy) begin errors++; $display("FAIL ns_ready_c%0d got=%b exp=%b", c, ns_in.ready, exp_rdy); end
            if (m_valid && ns_out.ready) begin
                checks++; if (ns_out.data !== out_seq) begin errors++; $display("FAIL ns_order_c%0d got=%h exp=%h", c, ns_out.data, out_seq); end
                out_seq++;
            end
            if (exp_rdy) begin m_valid = 1'b1; m_data = nxt; nxt++; end
            else if (m_valid && ns_out.ready) m_valid = 1'b0;
            step();
            checks++;
            if (ns_out.valid !== m_valid || (m_valid && ns_out.data !== m_data))
                begin errors++; $display("FAIL ns_state_c%0d got v=%b d=%h exp v=%b d=%h", c, ns_out.valid, ns_out.data, m_valid, m_data); end
        end
        ns_in.valid = 1'b0;
        checks++; if (out_seq !== 32'd12) begin errors++; $display("FAIL ns_count got=%0d exp=12", out_seq); end
    endtask

    task automatic test_saturate();
        c4_out.ready = 1'b0;
        c4_in.valid  = 1'b1;
        c4_in.data   = 8'h5A;
        step();
        c4_in.valid = 1'b0;
        checks++; if (c4_out.valid !== 1'b1 || c4_out.data !== 8'h5A || c4_stall !== 4'd0)
            begin errors++; $display("FAIL sat_load got v=%b d=%h cnt=%0d exp v=1 d=5a cnt=0", c4_out.valid, c4_out.data, c4_stall); end
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++; if (c4_stall !== ((k > 15) ? 4'd15 : 4'(k)))
                begin errors++; $display("FAIL sat_cnt_%0d got=%0d exp=%0d", k, c4_stall, (k > 15) ? 15 : k); end
        end
    endtask

    task automatic test_mid_reset();
        sk_out.ready = 1'b0;
        sk_in.valid  = 1'b1;
        sk_in.data   = 32'h21;
        step();
        sk_in.data = 32'h22;
        step();
        sk_in.valid = 1'b0;
        checks++; if (sk_occ !== 2'd2) begin errors++; $display("FAIL mrst_pre_occ got=%0d exp=2", sk_occ); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (sk_out.valid !== 1'b0 || sk_occ !== 2'd0) begin errors++; $display("FAIL mrst_async got v=%b occ=%0d exp v=0 occ=0", sk_out.valid, sk_occ); end
        checks++; if (sk_out.data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mrst_data got=%h exp=deadbeef", sk_out.data); end
        checks++; if (sk_stall !== 16'd0 || c4_stall !== 4'd0) begin errors++; $display("FAIL mrst_stall got sk=%0d c4=%0d exp 0 0", sk_stall, c4_stall); end
        #2;
        rst = 1'b0;
        step();
        checks++; if (sk_in.ready !== 1'b1 || sk_out.valid !== 1'b0) begin errors++; $display("FAIL mrst_release got rdy=%b v=%b exp rdy=1 v=0", sk_in.ready, sk_out.valid); end
    endtask

    initial begin
        sk_flush = 1'b0; ns_flush = 1'b0; c4_flush = 1'b0;
        sk_in.valid = 1'b0; sk_in.data = '0; sk_out.ready = 1'b0;
        ns_in.valid = 1'b0; ns_in.data = '0; ns_out.ready = 1'b0;
        c4_in.valid = 1'b0; c4_in.data = '0; c4_out.ready = 1'b0;
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_noskid();
        test_saturate();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
